// File: rtl/pix_pkg.sv
// Shared types and helpers for the pixel pipeline: frame-buffer FSM states,
// channel indices and a channel-slice accessor for packed pixels.
package pix_pkg;

  typedef enum logic {
    StFill,
    StDrain
  } pix_state_e;

  localparam int unsigned CH_R = 0;
  localparam int unsigned CH_G = 1;
  localparam int unsigned CH_B = 2;

  localparam int unsigned PixMaxW = 64;

  // Channel idx of a packed pixel with dw bits per channel, zero-extended.
  function automatic logic [PixMaxW-1:0] pix_channel(input logic [PixMaxW-1:0] pix,
                                                     input int unsigned idx,
                                                     input int unsigned dw);
    logic [PixMaxW-1:0] mask;
    mask = (dw >= PixMaxW) ? '1 : ((64'd1 << dw) - 64'd1);
    return (pix >> (idx * dw)) & mask;
  endfunction

endpackage

// File: rtl/pix_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module pix_frame_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = 12,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [PW-1:0] rdata
);

  logic [PW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pixel_frame_buffer.sv
// Single-frame pixel buffer: packs CH channel words per pixel into RAM, then replays
// the full frame with SOF/EOL markers. PIXEL_FRAME_BUFFER_MIRROR_EN reads lines right-to-left.
module pixel_frame_buffer
  import pix_pkg::*;
#(
  parameter int unsigned WIDTH  = 400,
  parameter int unsigned HEIGHT = 300,
  parameter int unsigned CH     = 3,
  parameter int unsigned DW     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             frame_done,
  output logic             sync_err
);

  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = CH * DW;
  localparam int unsigned CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [AW:0]   RdEnd   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   RdLast  = (AW+1)'(DEPTH - 1);
  localparam logic [AW-1:0] WrLast  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] ChLast  = CW'(CH - 1);
  localparam logic [XW-1:0] ColLast = XW'(WIDTH - 1);
  localparam logic [YW-1:0] RowLast = YW'(HEIGHT - 1);

  pix_state_e    state_q;
  logic [CW-1:0] ch_cnt_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic [XW-1:0] col_q;
  logic [YW-1:0] row_q;
  logic [PW-1:0] hold_q;
  logic          out_valid_q;
  logic          out_sof_q;
  logic          out_eol_q;
  logic          out_last_q;
  logic          sync_err_q;

  logic          in_hs;
  logic          resync;
  logic          pix_done;
  logic [CW-1:0] ch_sel;
  logic [AW-1:0] wr_sel;
  logic [PW-1:0] pix_word;
  logic          rd_issue;
  logic          last_out;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data;

  // An SOF word always lands in ch0 of pixel 0, whatever the counters say.
  always_comb begin
    in_hs    = (state_q == StFill) && in_valid;
    resync   = in_hs && in_sof && ((ch_cnt_q != '0) || (wr_ptr_q != '0));
    ch_sel   = in_sof ? '0 : ch_cnt_q;
    wr_sel   = in_sof ? '0 : wr_ptr_q;
    pix_word = hold_q;
    pix_word[32'(ch_sel) * DW +: DW] = in_data;
    pix_done = in_hs && (ch_sel == ChLast);
  end

  always_comb begin
    rd_issue = (state_q == StDrain) && (rd_ptr_q < RdEnd) && (!out_valid_q || out_ready);
    last_out = out_valid_q && out_ready && out_last_q;
`ifdef PIXEL_FRAME_BUFFER_MIRROR_EN
    rd_addr  = AW'(32'(row_q) * WIDTH + (WIDTH - 1) - 32'(col_q));
`else
    rd_addr  = rd_ptr_q[AW-1:0];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StFill;
      ch_cnt_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_last_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (in_hs) begin
            hold_q <= pix_word;
            if (resync) begin
              sync_err_q <= 1'b1;
            end
            if (pix_done) begin
              ch_cnt_q <= '0;
              if (wr_sel == WrLast) begin
                wr_ptr_q <= '0;
                state_q  <= StDrain;
              end else begin
                wr_ptr_q <= wr_sel + 1'b1;
              end
            end else begin
              ch_cnt_q <= ch_sel + 1'b1;
              wr_ptr_q <= wr_sel;
            end
          end
        end
        StDrain: begin
          // RAM data appears on the same edge the markers load, so they stay aligned.
          if (rd_issue) begin
            out_valid_q <= 1'b1;
            out_sof_q   <= (rd_ptr_q == '0);
            out_eol_q   <= (col_q == ColLast);
            out_last_q  <= (rd_ptr_q == RdLast);
            rd_ptr_q    <= rd_ptr_q + 1'b1;
            if (col_q == ColLast) begin
              col_q <= '0;
              row_q <= (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_last_q  <= 1'b0;
          end
          if (last_out) begin
            rd_ptr_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            state_q  <= StFill;
          end
        end
      endcase
    end
  end

  pix_frame_ram #(
    .DEPTH(DEPTH),
    .PW   (PW),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (pix_done),
    .waddr(wr_sel),
    .wdata(pix_word),
    .re   (rd_issue),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  assign in_ready   = (state_q == StFill);
  assign out_valid  = out_valid_q;
  assign out_data   = out_valid_q ? rd_data : '0;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign frame_done = last_out;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Testbench for pixel_frame_buffer on a 4x2 frame: timing table, back-pressure, resync,
// mid-drain reset and random frames against a word-level frame model.
module tb_pixel_frame_buffer;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned HEIGHT = 2;
  localparam int unsigned CH     = 3;
  localparam int unsigned DW     = 4;
  localparam int unsigned DEPTH  = WIDTH * HEIGHT;
  localparam int unsigned PW     = CH * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          frame_done;
  logic          sync_err;

  pixel_frame_buffer #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .CH    (CH),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eol   (out_eol),
    .frame_done(frame_done),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [PW-1:0] data;
    logic          sof;
    logic          eol;
  } exp_t;

  typedef struct {
    logic          valid;
    logic          sof;
    logic          eol;
    logic          done;
    logic          rdy;
    logic [PW-1:0] data;
  } vec_t;

  // Frame model: word index within the frame and the pixels it has assembled.
  logic [PW-1:0] mdl_frame [DEPTH];
  int            mdl_idx  = 0;
  logic          mdl_sync = 1'b0;
  exp_t          exp_q[$];
  vec_t          tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_word(input logic [DW-1:0] d, input logic sof);
    int p;
    int c;
    exp_t e;
    if (sof) begin
      if (mdl_idx != 0) mdl_sync = 1'b1;
      mdl_idx = 0;
    end
    p = mdl_idx / CH;
    c = mdl_idx % CH;
    mdl_frame[p][c*DW +: DW] = d;
    mdl_idx++;
    if (mdl_idx == DEPTH * CH) begin
      mdl_idx = 0;
      for (int o = 0; o < DEPTH; o++) begin
        int r;
        int x;
        int a;
        r = o / WIDTH;
        x = o % WIDTH;
`ifdef PIXEL_FRAME_BUFFER_MIRROR_EN
        a = r * WIDTH + (WIDTH - 1 - x);
`else
        a = o;
`endif
        e.data = mdl_frame[a];
        e.sof  = (o == 0);
        e.eol  = (x == WIDTH - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic sof);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    chk("in_ready_fill", 32'(in_ready), 32'd1);
    model_word(d, sof);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // mode 0: words 1,2,3; mode 1: ch0 = pixel index, rest random; mode 2: all random.
  task automatic fill_frame(input int mode);
    for (int p = 0; p < DEPTH; p++) begin
      for (int c = 0; c < CH; c++) begin
        logic [DW-1:0] w;
        if (mode == 0) w = DW'(c + 1);
        else if (mode == 1 && c == 0) w = DW'(p);
        else w = DW'($urandom);
        send_word(w, (p == 0 && c == 0));
      end
    end
  endtask

  // mode 0: ready held; mode 1: ready pattern 1,0,0,1; mode 2: random ready.
  task automatic drain(input int mode, input int n_pix);
    int            got = 0;
    int            cyc = 0;
    bit            stall = 0;
    logic [PW-1:0] hd = '0;
    logic          hs = 1'b0;
    logic          he = 1'b0;
    exp_t          e;
    while (got < n_pix && cyc < 40 * DEPTH) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      chk("in_ready_drain", 32'(in_ready), 32'd0);
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(hd));
        chk("stall_sof", 32'(out_sof), 32'(hs));
        chk("stall_eol", 32'(out_eol), 32'(he));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_pixel", 32'(out_data), 32'hdead);
        end else begin
          e = exp_q.pop_front();
          chk("pix_data", 32'(out_data), 32'(e.data));
          chk("pix_sof", 32'(out_sof), 32'(e.sof));
          chk("pix_eol", 32'(out_eol), 32'(e.eol));
          chk("frame_done_at_pix", 32'(frame_done), 32'(exp_q.size() == 0));
        end
        got++;
      end else begin
        chk("frame_done_idle", 32'(frame_done), 32'd0);
      end
      stall = out_valid && !out_ready;
      hd    = out_data;
      hs    = out_sof;
      he    = out_eol;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("drain_count", 32'(got), 32'(n_pix));
  endtask

  task automatic post_drain();
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_frame_done", 32'(frame_done), 32'd0);
  endtask

  initial begin
    // Timeline after the final input handshake, out_ready held and in_valid pushing.
    tbl[0] = '{valid: 0, sof: 0, eol: 0, done: 0, rdy: 0, data: 12'h000};
    tbl[1] = '{valid: 1, sof: 1, eol: 0, done: 0, rdy: 0, data: 12'h321};
    tbl[2] = '{valid: 1, sof: 0, eol: 0, done: 0, rdy: 0, data: 12'h321};
    tbl[3] = '{valid: 1, sof: 0, eol: 0, done: 0, rdy: 0, data: 12'h321};
    tbl[4] = '{valid: 1, sof: 0, eol: 1, done: 0, rdy: 0, data: 12'h321};
    tbl[5] = '{valid: 1, sof: 0, eol: 0, done: 0, rdy: 0, data: 12'h321};
    tbl[6] = '{valid: 1, sof: 0, eol: 0, done: 0, rdy: 0, data: 12'h321};
    tbl[7] = '{valid: 1, sof: 0, eol: 0, done: 0, rdy: 0, data: 12'h321};
    tbl[8] = '{valid: 1, sof: 0, eol: 1, done: 1, rdy: 0, data: 12'h321};
    tbl[9] = '{valid: 0, sof: 0, eol: 0, done: 0, rdy: 1, data: 12'h000};

    // Reset state.
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sof", 32'(out_sof), 32'd0);
    chk("rst_eol", 32'(out_eol), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Fixed fill, then cycle-exact drain timeline with input pushing during DRAIN.
    fill_frame(0);
    exp_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'hf;
    for (int k = 0; k < 10; k++) begin
      chk("tbl_valid", 32'(out_valid), 32'(tbl[k].valid));
      chk("tbl_sof", 32'(out_sof), 32'(tbl[k].sof));
      chk("tbl_eol", 32'(out_eol), 32'(tbl[k].eol));
      chk("tbl_done", 32'(frame_done), 32'(tbl[k].done));
      chk("tbl_in_ready", 32'(in_ready), 32'(tbl[k].rdy));
      if (tbl[k].valid) chk("tbl_data", 32'(out_data), 32'(tbl[k].data));
      if (k < 9) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    chk("tbl_sync_err", 32'(sync_err), 32'd0);

    // Output back-pressure with unique ch0 values.
    out_ready = 1'b0;
    fill_frame(1);
    drain(1, DEPTH);
    post_drain();

    // Mid-frame resync on the 7th word, then a full frame from there.
    for (int i = 0; i < 6; i++) send_word(DW'($urandom), (i == 0));
    chk("resync_before", 32'(sync_err), 32'd0);
    send_word(DW'(0), 1'b1);
    chk("resync_set", 32'(sync_err), 32'(mdl_sync));
    for (int i = 1; i < DEPTH * CH; i++) begin
      logic [DW-1:0] w;
      w = ((i % CH) == 0) ? DW'(i / CH) : DW'($urandom);
      send_word(w, 1'b0);
    end
    chk("resync_frame_ready", 32'(exp_q.size()), 32'(DEPTH));
    drain(2, DEPTH);
    post_drain();
    chk("resync_sticky", 32'(sync_err), 32'd1);

    // Asynchronous reset after pixel 3 of a drain.
    fill_frame(1);
    drain(0, 4);
    #3 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    #2 reset = 1'b1;
    exp_q.delete();
    mdl_idx  = 0;
    mdl_sync = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_no_done", 32'(frame_done), 32'd0);
    chk("arst_sync_clr", 32'(sync_err), 32'd0);
    fill_frame(1);
    drain(0, DEPTH);
    post_drain();

    // Random frames with random downstream readiness.
    for (int f = 0; f < 3; f++) begin
      fill_frame(2);
      drain(2, DEPTH);
      post_drain();
    end
    chk("final_sync_err", 32'(sync_err), 32'(mdl_sync));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_frame_buffer.md
Name: pixel_frame_buffer

Overview:
- Single-frame pixel buffer with parametrised frame size, channel count and channel width.
- Accepts one channel word per handshake, assembles CH words into one packed pixel and stores one pixel per address in a single RAM.
- Once a full frame is stored, replays it as a packed-pixel stream with valid/ready, start-of-frame and end-of-line markers.
- Sits between the channel-serial data-pack stage and the per-pixel filter and blur stages.

Parameters:
- WIDTH, 400, pixels per line.
- HEIGHT, 300, lines per frame.
- CH, 3, channels per pixel, sent in order ch0 (R), ch1 (G), ch2 (B).
- DW, 4, bits per channel.
- Derived localparams (not overridable): DEPTH = WIDTH*HEIGHT; AW = $clog2(DEPTH); PW = CH*DW.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input channel word valid.
- in_ready  out  1  buffer can accept a channel word.
- in_data  in  DW  channel word.
- in_sof  in  1  marks ch0 of pixel 0 of a frame.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the pixel.
- out_data  out  PW  packed pixel; ch0 in bits [DW-1:0], ch(k) in bits [k*DW +: DW].
- out_sof  out  1  qualifies out_data as pixel 0 of the frame.
- out_eol  out  1  qualifies out_data as the last pixel of a line.
- frame_done  out  1  one-cycle pulse when the last pixel of the frame is accepted downstream.
- sync_err  out  1  sticky; in_sof was seen mid-frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to FILL; all pointers and counters are 0.
  - out_valid, out_data, out_sof, out_eol, frame_done and sync_err are 0; in_ready is 1 after release.
  - RAM contents are not cleared.
  - A reset mid-FILL or mid-DRAIN abandons the frame; no frame_done is issued.
- FSM has two states, FILL and DRAIN.
- FILL:
  - in_ready=1, out_valid=0.
  - On each handshake (in_valid & in_ready), in_data goes into channel slot ch_cnt of the holding register, and ch_cnt increments.
  - When ch_cnt=CH-1, the completed pixel (holding register plus the current word) is written to RAM[wr_ptr] in that same cycle. ch_cnt then returns to 0 and wr_ptr increments.
  - Writing pixel DEPTH-1 sets wr_ptr to 0 and moves the FSM to DRAIN on the next cycle.
- in_sof handling (only on a handshake):
  - The word is forced to ch0 of pixel 0.
  - If ch_cnt≠0 or wr_ptr≠0 at that moment, sync_err is set to 1 and the partial frame is discarded.
  - in_sof with pointers already at 0 is legal and sets no error.
- DRAIN:
  - in_ready=0.
  - The RAM has a registered read with 1-cycle latency.
  - A read of RAM[rd_ptr] is issued when rd_ptr has not reached DEPTH and (!out_valid | out_ready).
  - The output register loads on the cycle after the issue: out_valid=1, out_sof=(addr==0), out_eol=(col==WIDTH-1).
  - If out_ready=1 and no read is issued, out_valid drops to 0.
  - out_data, out_sof and out_eol stay stable while out_valid=1 and out_ready=0.
  - The first read is issued in the first DRAIN cycle, so out_valid rises 2 cycles after the final input handshake.
  - With out_ready held at 1, one pixel is output per cycle with no bubbles.
- Column and row counters track the read address. Column wraps WIDTH-1→0 and increments the row; row wraps HEIGHT-1→0.
- When the last pixel handshakes:
  - frame_done=1 for exactly 1 cycle.
  - rd_ptr, column and row return to 0.
  - The FSM returns to FILL on the next cycle, with in_ready=1 on that cycle.
- Simultaneous events: fill and drain never overlap. An input offered during DRAIN is simply back-pressured.

Optional Feature:
- Macro: PIXEL_FRAME_BUFFER_MIRROR_EN.
- When defined, DRAIN reads each line right-to-left: read address = row*WIDTH + (WIDTH-1-col).
  - out_sof still marks the first pixel output (address WIDTH-1).
  - out_eol still marks the last pixel output in each line.
- When undefined, read address = rd_ptr (raster order) and no mirror logic is built.

Decomposition:
- Shared package pix_pkg holds:
  - the FILL/DRAIN state enum;
  - channel index constants CH_R=0, CH_G=1, CH_B=2;
  - a function returning the channel slice of a packed pixel, used by the downstream blur stages.
- One sub-module: pix_frame_ram, a simple dual-port RAM (DEPTH x PW) with one write port and one registered read port, so synthesis infers block RAM.

Test Plan:
- Reset then fill (WIDTH=4, HEIGHT=2, CH=3, DW=4); send words 0x1,0x2,0x3 per pixel, all 8 pixels -> out_data=12'h321 on every pixel; out_valid rises 2 cycles after the 24th handshake; out_sof on pixel 0; out_eol on pixels 3 and 7; frame_done pulses once.
- Back-pressure: toggle out_ready 1,0,0,1 during DRAIN -> out_data held stable while stalled; no pixel duplicated or dropped (8 pixels, unique values 0..7 in ch0).
- Mid-frame resync: in_sof asserted on the 7th input word -> sync_err=1 sticky; next 24 words form a full frame and drain correctly.
- Back-pressure on input: in_valid=1 throughout DRAIN -> in_ready=0 and no RAM write; in_ready=1 the cycle after frame_done.
- Asynchronous reset asserted mid-DRAIN (after pixel 3) -> out_valid=0 immediately, no frame_done; a refill then drains a full 8-pixel frame.
- With PIXEL_FRAME_BUFFER_MIRROR_EN and ch0 values 0..7 -> output ch0 order 3,2,1,0,7,6,5,4.
